serial_add_ctrl: RTL
====================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: W, default 8, operand width in bits (legal 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request a new addition; sampled only in IDLE or DONE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 a  input  W  operand A; captured on accepted start.
REQ-007 b  input  W  operand B; captured on accepted start.
REQ-008 cIn  input  1  carry-in; captured on accepted start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 z  output  W  sum result; held stable outside RUN.
REQ-012 cOut  output  1  final carry-out; held stable outside RUN.

Function
REQ-013 The block SHALL compute {cOut,z} = a + b + cIn bit-serially, using one full-adder cell (sum = x^y^c, carry = majority) over W cycles.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-015 IDLE -> RUN on start=1: load A and B shift registers, load the carry flop with cIn, clear the bit counter to 0.
REQ-016 In each RUN cycle, the block SHALL feed A[0], B[0] and the carry flop to the cell, shift A, B and the result register right by one, insert the sum bit at the result MSB, and store the cell carry.
REQ-017 RUN -> DONE after exactly W RUN cycles (counter == W-1 at the transition edge).
REQ-018 DONE lasts exactly one cycle: done=1, z and cOut valid.
REQ-019 DONE -> RUN if start=1 in the DONE cycle (back-to-back operation); otherwise DONE -> IDLE.
REQ-020 Latency: start accepted at edge k; busy=1 for cycles k+1..k+W; done=1 in cycle k+W+1.
REQ-021 start while busy SHALL be ignored; it SHALL NOT be queued.
REQ-022 abort=1 in RUN SHALL force IDLE on the next edge, with no done pulse; z and cOut SHALL keep their pre-operation values.
REQ-023 abort SHALL have priority over RUN completion in the same cycle; abort SHALL be ignored in IDLE and DONE.
REQ-024 z and cOut SHALL update only at the RUN -> DONE transition, from internal shift and carry registers.
REQ-025 Wrap-around: the carry out of the MSB SHALL appear on cOut; no overflow is lost or saturated.

Reset
REQ-026 On rst_n=0, asynchronously: state=IDLE, busy=0, done=0, z=0, cOut=0, counter=0, internal registers=0.
REQ-027 Reset asserted mid-RUN SHALL discard the operation; no done pulse after release.
REQ-028 The first start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-029 Macro SERIAL_ADD_OVF_EN: when defined, an added output ovf (1 bit) SHALL be updated with z and cleared at reset, and SHALL equal the XOR of the carry into and the carry out of the MSB (signed overflow).
REQ-030 Without SERIAL_ADD_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-031 W=8, a=8'h0F, b=8'h01, cIn=0, start for one cycle -> busy high for 8 cycles, done in cycle 9, z=8'h10, cOut=0.
REQ-032 W=8, a=8'hFF, b=8'h00, cIn=1 -> z=8'h00, cOut=1 (wrap-around); with SERIAL_ADD_OVF_EN, ovf=0.
REQ-033 With SERIAL_ADD_OVF_EN, a=8'h7F, b=8'h01, cIn=0 -> z=8'h80, cOut=0, ovf=1.
REQ-034 Start a=3,b=4; pulse start again mid-RUN with a=9 -> second start ignored, z=7; start held during the DONE cycle with a=1,b=1 -> busy again next cycle, z=2 after W cycles.
REQ-035 abort in RUN cycle 4, and separately rst_n low in RUN cycle 5 -> no done pulse in either case, z and cOut unchanged or cleared respectively, state IDLE.
REQ-036 Exhaustive sweep: for W=4, all a, b and cIn combinations -> {cOut,z} equals the reference sum in every case.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {cOut,z} = a + b + cIn using one full-adder cell over W cycles.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output ovf.
module serial_add_ctrl #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cIn,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] z,
    output logic         cOut
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-2:0]  r_q;
    logic [W-1:0]  z_q;
    logic          c_q;
    logic          cout_q;
    logic          busy_q;
    logic          done_q;
    logic [CW-1:0] cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    logic          ovf_q;
`endif

    logic         sum_d;
    logic         carry_d;
    logic [W-1:0] r_d;

    assign sum_d   = a_q[0] ^ b_q[0] ^ c_q;
    assign carry_d = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
    // Full result word including the bit produced this cycle; the register keeps only the upper W-1 bits.
    assign r_d     = {sum_d, r_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            z_q     <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        a_q <= a_q >> 1;
                        b_q <= b_q >> 1;
                        r_q <= r_d[W-1:1];
                        c_q <= carry_d;
                        if (cnt_q == CNT_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            z_q     <= r_d;
                            cout_q  <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
                            // c_q is the carry into the MSB on this final cycle
                            ovf_q   <= c_q ^ carry_d;
`endif
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= cIn;
                        cnt_q   <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign cOut = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
